// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
//   fetch_state_t : fetch FSM states (RUN, WAIT, DRAIN)
//   fetch_entry_t : one buffered fetch result {instr, pc}
//   align_pc      : force a redirect target onto a word boundary
package if_pkg;

  localparam int unsigned INSTR_W     = 32;
  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t between the fetch FSM and decode.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   push_i, entry_i   : write one entry
//   pop_i             : drop the head entry
//   flush_i           : empty the FIFO; wins over push and pop
//   head_o            : head entry, read straight from the storage flops
//   count_o, full_o, empty_o : occupancy status
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  fetch_entry_t    entry_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output fetch_entry_t    head_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit feeding the IF/ID register. Keeps a single request
// outstanding to instruction memory, buffers returned words with their PCs and
// hands them to decode over a valid/ready handshake; handles stall and redirect.
// Ports:
//   clk, reset (async, active low)
//   imem_req/imem_addr   : one-cycle request pulse and its address
//   imem_ack/imem_rdata  : response strobe and instruction word
//   branch_taken/target  : redirect strobe and new PC (low two bits ignored)
//   id_ready             : decode accepts the head entry this cycle
//   if_valid/instruction/pc : head entry presented to decode
//   perf_stall_cnt       : only when IF_PERF_CNT_EN is defined; saturating count
//                          of cycles with if_valid && !id_ready
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 64'h0,
  parameter int unsigned       FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              req_q, req_d;

  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  fetch_entry_t      push_entry, head;

  logic              ack_valid, still_out, push, pop, room;
  int unsigned       count_next;
  logic [ADDR_W-1:0] pc_base;

  // An ack in the request cycle is illegal and an ack in RUN is spurious;
  // both are ignored.
  assign ack_valid  = imem_ack && (state_q != RUN) && !req_q;
  assign still_out  = (state_q != RUN) && !ack_valid;
  // Only WAIT acks carry live data; DRAIN acks belong to a squashed request.
  assign push       = ack_valid && (state_q == WAIT) && !branch_taken;
  assign pop        = if_valid && id_ready && !branch_taken;
  assign pc_base    = branch_taken ? align_pc(branch_target) : fetch_pc_q;
  assign count_next = branch_taken ? 32'd0 : (32'(fifo_count) + 32'(push) - 32'(pop));
  // Nothing is outstanding after this edge, so only buffered entries use up room.
  assign room       = (count_next < FIFO_DEPTH);

  // The request is registered but decided on the edge that frees the slot,
  // giving one request every two cycles and a target request the cycle after
  // a redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = pc_base;
    req_pc_d   = req_pc_q;
    req_d      = 1'b0;
    if (!still_out && room) begin
      req_d      = 1'b1;
      req_pc_d   = pc_base;
      fetch_pc_d = pc_base + ADDR_W'(INSTR_BYTES);
      state_d    = WAIT;
    end else if (still_out) begin
      if (branch_taken) begin
        state_d = DRAIN;
      end
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_q      <= req_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = req_pc_q;
  // req_pc_q holds the outstanding request's address until the next issue.
  assign push_entry = '{instr: imem_rdata, pc: req_pc_q};

  if_fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (branch_taken),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (),
    .empty_o (fifo_empty)
  );

  assign if_valid    = !fifo_empty;
  assign instruction = head.instr;
  assign pc          = head.pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (if_valid && !id_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] instruction;
  logic [63:0] pc;

  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [63:0] w_pc;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] w_perf;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC   (64'h0),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .id_ready      (id_ready),
    .if_valid      (if_valid),
    .instruction   (instruction),
    .pc            (pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Second instance only exercises 64-bit PC wrap from a high reset PC.
  if_fetch_unit #(
    .RESET_PC   (WRAP_PC),
    .FIFO_DEPTH (DEPTH)
  ) u_dut_wrap (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (w_req),
    .imem_addr     (w_addr),
    .imem_ack      (w_ack),
    .imem_rdata    (w_rdata),
    .branch_taken  (1'b0),
    .branch_target (64'h0),
    .id_ready      (1'b1),
    .if_valid      (w_valid),
    .instruction   (w_instr),
    .pc            (w_pc)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_stall_cnt (w_perf)
`endif
  );

  int n_tests;
  int n_fail;

  // Reference model: queue of PCs buffered for decode plus one request slot.
  logic [63:0] m_q[$];
  bit          m_out;
  bit          m_stale;
  bit          m_req_exp;
  logic [63:0] m_req_pc;
  logic [63:0] m_fetch;
  int          m_wait;
  int          m_lat;
  int          lat_min;
  int          lat_max;
  int          m_stall;
  bit          inj_ack;
  logic [63:0] req_log[$];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[33:2] ^ a[63:32] ^ 32'h5A3C_96E1;
  endfunction

  task automatic model_init();
    m_q.delete();
    m_out     = 1'b0;
    m_stale   = 1'b0;
    m_req_exp = 1'b0;
    m_req_pc  = 64'h0;
    m_fetch   = 64'h0;
    m_wait    = 0;
    m_lat     = 1;
    m_stall   = 0;
    inj_ack   = 1'b0;
  endtask

  // Entered and left on a falling edge: check outputs, drive inputs for the
  // next rising edge, advance the model over that edge.
  task automatic cycle(input bit br, input logic [63:0] tgt, input bit rdy);
    bit ack;
    bit pop;
    bit out_after;
    n_tests++;
    if (imem_req !== m_req_exp) begin
      n_fail++;
      $display("FAIL req_timing t=%0t got %b exp %b", $time, imem_req, m_req_exp);
    end
    if (m_req_exp) begin
      n_tests++;
      if (imem_addr !== m_req_pc) begin
        n_fail++;
        $display("FAIL req_addr t=%0t got %h exp %h", $time, imem_addr, m_req_pc);
      end
      req_log.push_back(imem_addr);
    end
    n_tests++;
    if (if_valid !== (m_q.size() != 0)) begin
      n_fail++;
      $display("FAIL if_valid t=%0t got %b exp %b", $time, if_valid, m_q.size() != 0);
    end
    if (m_q.size() != 0) begin
      n_tests++;
      if (pc !== m_q[0] || instruction !== word_of(m_q[0])) begin
        n_fail++;
        $display("FAIL head t=%0t got pc %h instr %h exp pc %h instr %h", $time, pc,
                 instruction, m_q[0], word_of(m_q[0]));
      end
    end

    ack = 1'b0;
    if (m_req_exp) begin
      m_wait = 0;
      m_lat  = $urandom_range(lat_max, lat_min);
    end else if (m_out) begin
      m_wait++;
      ack = (m_wait >= m_lat);
    end

    imem_ack      = ack | inj_ack;
    imem_rdata    = ack ? word_of(m_req_pc) : $urandom;
    branch_taken  = br;
    branch_target = tgt;
    id_ready      = rdy;

    if (m_q.size() != 0 && !rdy) m_stall++;
    pop = (m_q.size() != 0) && rdy;
    if (br) begin
      m_q.delete();
      m_fetch = {tgt[63:2], 2'b00};
    end else begin
      if (pop) void'(m_q.pop_front());
      if (ack && !m_stale) m_q.push_back(m_req_pc);
    end
    out_after = m_out && !ack;
    if (br && out_after) m_stale = 1'b1;
    if (!out_after && m_q.size() < DEPTH) begin
      m_req_exp = 1'b1;
      m_req_pc  = m_fetch;
      m_fetch   = m_fetch + 64'd4;
      m_out     = 1'b1;
      m_stale   = 1'b0;
    end else begin
      m_req_exp = 1'b0;
      m_out     = out_after;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    id_ready      = 1'b0;
    w_ack         = 1'b0;
    w_rdata       = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    model_init();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    imem_ack      = 1'b1;
    imem_rdata    = $urandom;
    branch_taken  = 1'b1;
    branch_target = {$urandom, $urandom};
    id_ready      = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 ||
        instruction !== 32'h0 || pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got req %b addr %h valid %b instr %h pc %h exp all zero",
               imem_req, imem_addr, if_valid, instruction, pc);
    end
    n_tests++;
    if (w_addr !== WRAP_PC || w_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_addr_wrap got %h exp %h", w_addr, WRAP_PC);
    end
`ifdef IF_PERF_CNT_EN
    n_tests++;
    if (perf_stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf got %0d exp 0", perf_stall_cnt);
    end
`endif
    do_reset();
    repeat (4) cycle(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_stream();
    int base;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    base    = req_log.size();
    repeat (14) cycle(1'b0, 64'h0, 1'b1);
    n_tests++;
    if (req_log.size() < base + 3) begin
      n_fail++;
      $display("FAIL stream_count got %0d exp >=3", req_log.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (req_log[base+k] !== 64'(4 * k)) begin
          n_fail++;
          $display("FAIL stream_addr%0d got %h exp %h", k, req_log[base+k], 64'(4 * k));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat_min = 1;
    lat_max = 1;
    repeat (10) cycle(1'b0, 64'h0, 1'b0);
    n_tests++;
    if (imem_req !== 1'b0 || if_valid !== 1'b1 || pc !== 64'h0 ||
        instruction !== word_of(64'h0)) begin
      n_fail++;
      $display("FAIL stall_hold got req %b valid %b pc %h instr %h exp 0 1 0 %h",
               imem_req, if_valid, pc, instruction, word_of(64'h0));
    end
    repeat (12) cycle(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_redirect_wait();
    int base;
    bit found;
    do_reset();
    lat_min = 5;
    lat_max = 5;
    found   = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (m_out && !m_req_exp) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 64'h0, 1'b1);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL redirect_wait_setup got no WAIT exp WAIT within 20 cycles");
    end
    base = req_log.size();
    cycle(1'b1, 64'h1003, 1'b1);
    n_tests++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_wait_valid got %b exp 0", if_valid);
    end
    lat_min = 1;
    lat_max = 2;
    repeat (20) cycle(1'b0, 64'h0, 1'b1);
    n_tests++;
    if (req_log.size() <= base || req_log[base] !== 64'h1000) begin
      n_fail++;
      $display("FAIL redirect_wait_target got %h exp %h",
               (req_log.size() > base) ? req_log[base] : 64'hx, 64'h1000);
    end
  endtask

  task automatic test_redirect_pop_push();
    logic [63:0] tgt;
    bit          found;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (m_q.size() >= 1 && m_out && !m_req_exp && (m_wait + 1 >= m_lat)) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 64'h0, 1'b0);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL redirect_pp_setup got no pop+push cycle exp one within 30 cycles");
    end
    tgt = {$urandom, $urandom};
    cycle(1'b1, tgt, 1'b1);
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== {tgt[63:2], 2'b00}) begin
      n_fail++;
      $display("FAIL redirect_pp got valid %b req %b addr %h exp 0 1 %h", if_valid, imem_req,
               imem_addr, {tgt[63:2], 2'b00});
    end
    repeat (10) cycle(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    bit          br;
    do_reset();
    lat_min = 1;
    lat_max = 4;
    for (int t = 0; t < 400; t++) begin
      br  = ($urandom_range(19, 0) == 0);
      tgt = {$urandom, $urandom};
      if ($urandom_range(3, 0) == 0) tgt[63:8] = '1;
      cycle(br, tgt, $urandom_range(3, 0) != 0);
    end
`ifdef IF_PERF_CNT_EN
    n_tests++;
    if (perf_stall_cnt !== 32'(m_stall)) begin
      n_fail++;
      $display("FAIL random_perf got %0d exp %0d", perf_stall_cnt, m_stall);
    end
`endif
  endtask

  task automatic test_wrap();
    logic [63:0] exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp = WRAP_PC + 64'(4 * i);
      for (int t = 0; t < 10 && !w_req; t++) @(negedge clk);
      n_tests++;
      if (w_req !== 1'b1 || w_addr !== exp) begin
        n_fail++;
        $display("FAIL wrap_addr%0d got req %b addr %h exp 1 %h", i, w_req, w_addr, exp);
      end
      @(negedge clk);
      w_ack   = 1'b1;
      w_rdata = word_of(exp);
      @(negedge clk);
      w_ack   = 1'b0;
      n_tests++;
      if (w_valid !== 1'b1 || w_pc !== exp || w_instr !== word_of(exp)) begin
        n_fail++;
        $display("FAIL wrap_pc%0d got valid %b pc %h instr %h exp 1 %h %h", i, w_valid, w_pc,
                 w_instr, exp, word_of(exp));
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    bit found;
    do_reset();
    lat_min = 1;
    lat_max = 1;
    found   = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (m_q.size() >= 1 && m_out && !m_req_exp) begin
        found = 1'b1;
        break;
      end
      cycle(1'b0, 64'h0, 1'b0);
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_setup got no WAIT exp WAIT within 20 cycles");
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (imem_req !== 1'b0 || imem_addr !== 64'h0 || if_valid !== 1'b0 ||
        instruction !== 32'h0 || pc !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_async got req %b addr %h valid %b instr %h pc %h exp all zero",
               imem_req, imem_addr, if_valid, instruction, pc);
    end
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    @(negedge clk);
    imem_ack = 1'b0;
    n_tests++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_ack got valid %b req %b exp 0 0", if_valid, imem_req);
    end
    model_init();
    reset   = 1'b1;
    base    = req_log.size();
    inj_ack = 1'b1;
    cycle(1'b0, 64'h0, 1'b1);
    inj_ack = 1'b0;
    repeat (3) cycle(1'b0, 64'h0, 1'b1);
    n_tests++;
    if (req_log.size() <= base || req_log[base] !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid_first got %h exp %h",
               (req_log.size() > base) ? req_log[base] : 64'hx, 64'h0);
    end
    for (int t = 0; t < 10 && m_q.size() == 0; t++) cycle(1'b0, 64'h0, 1'b1);
    repeat (10) cycle(1'b0, 64'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    n_tests++;
    if (perf_stall_cnt !== 32'd10) begin
      n_fail++;
      $display("FAIL perf_stall got %0d exp 10", perf_stall_cnt);
    end
`endif
    repeat (6) cycle(1'b0, 64'h0, 1'b1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    lat_min = 1;
    lat_max = 1;
    reset   = 1'b0;
    clear_inputs();
    model_init();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_pop_push();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish exp finish before 500000");
    $fatal(1, "timeout");
  end

endmodule
